// File: rtl/adsr_envelope_if.sv
//------------------------------------------------------------------------------
// Module   : adsr_envelope_if
// Summary  : Control, sample and status bundle for one ADSR envelope voice.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface adsr_envelope_if #(
    parameter int BITDEPTH = 14,
    parameter int ENVBITS  = 12
);
    logic                sample_clock;
    logic                gate;
    logic [ENVBITS-1:0]  attack_step;
    logic [ENVBITS-1:0]  decay_step;
    logic [ENVBITS-1:0]  sustain_level;
    logic [ENVBITS-1:0]  release_step;
    logic [BITDEPTH-1:0] pcm_in;
    logic [BITDEPTH-1:0] pcm_out;
    logic                out_strobe;
    logic [ENVBITS-1:0]  env_level;
    logic                active;

    modport master (
        output sample_clock, gate, attack_step, decay_step, sustain_level,
               release_step, pcm_in,
        input  pcm_out, out_strobe, env_level, active
    );

    modport slave (
        input  sample_clock, gate, attack_step, decay_step, sustain_level,
               release_step, pcm_in,
        output pcm_out, out_strobe, env_level, active
    );
endinterface

`default_nettype wire

// File: rtl/adsr_envelope.sv
//------------------------------------------------------------------------------
// Module   : adsr_envelope
// Summary  : Per-voice ADSR envelope scaling unsigned PCM about mid-scale.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module adsr_envelope #(
    parameter int BITDEPTH = 14,
    parameter int ENVBITS  = 12
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    adsr_envelope_if.slave   bus
);

    localparam logic [ENVBITS-1:0]  ENV_MAX   = '1;
    localparam logic [BITDEPTH-1:0] MID_SCALE = {1'b1, {(BITDEPTH-1){1'b0}}};
    localparam int                  PW        = BITDEPTH + ENVBITS + 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ENVBITS-1:0]  env_q, env_d;
    logic                sample_clock_q;
    logic [BITDEPTH-1:0] pcm_cap_q, pcm_cap_d;
    logic                update_q, update_d;
    logic [BITDEPTH-1:0] pcm_out_q, pcm_out_d;
    logic                out_strobe_q, out_strobe_d;

    logic                tick;
    logic [ENVBITS:0]    attack_sum;
    logic [ENVBITS:0]    decay_diff;
    logic [ENVBITS:0]    release_diff;
    logic                attack_done;
    logic                decay_done;
    logic                release_done;
    logic [ENVBITS-1:0]  attack_env;
    state_t              attack_state;

    assign tick = bus.sample_clock & ~sample_clock_q;

    // One extra bit on each step result exposes overflow/underflow directly.
    assign attack_sum   = {1'b0, env_q} + {1'b0, bus.attack_step};
    assign decay_diff   = {1'b0, env_q} - {1'b0, bus.decay_step};
    assign release_diff = {1'b0, env_q} - {1'b0, bus.release_step};

    assign attack_done  = (bus.attack_step == '0) || (attack_sum >= {1'b0, ENV_MAX});
    assign decay_done   = (bus.decay_step == '0) || decay_diff[ENVBITS]
                          || (decay_diff[ENVBITS-1:0] <= bus.sustain_level);
    assign release_done = (bus.release_step == '0) || release_diff[ENVBITS]
                          || (release_diff == '0);

    assign attack_env   = attack_done ? ENV_MAX : attack_sum[ENVBITS-1:0];
    assign attack_state = attack_done ? ST_DECAY : ST_ATTACK;

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (tick) begin
            if (state_q == ST_IDLE) begin
                if (bus.gate) begin
                    state_d = attack_state;
                    env_d   = attack_env;
                end else begin
                    env_d   = '0;
                end
            end else if (!bus.gate) begin
                state_d = release_done ? ST_IDLE : ST_RELEASE;
                env_d   = release_done ? '0 : release_diff[ENVBITS-1:0];
            end else begin
                case (state_q)
                    // A retrigger from RELEASE keeps the current level to avoid a click.
                    ST_ATTACK, ST_RELEASE: begin
                        state_d = attack_state;
                        env_d   = attack_env;
                    end
                    ST_DECAY: begin
                        state_d = decay_done ? ST_SUSTAIN : ST_DECAY;
                        env_d   = decay_done ? bus.sustain_level : decay_diff[ENVBITS-1:0];
                    end
                    ST_SUSTAIN: begin
                        env_d   = bus.sustain_level;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        env_d   = '0;
                    end
                endcase
            end
        end
    end

    logic signed [BITDEPTH:0] centered;
    logic signed [PW-1:0]     centered_ext;
    logic signed [PW-1:0]     env_ext;
    logic signed [PW-1:0]     product;
    logic signed [PW-1:0]     shifted;

    assign centered     = $signed({1'b0, pcm_cap_q}) - $signed({1'b0, MID_SCALE});
    assign centered_ext = {{(PW-BITDEPTH-1){centered[BITDEPTH]}}, centered};
    assign env_ext      = {{(PW-ENVBITS){1'b0}}, env_q};
    assign product      = centered_ext * env_ext;
    // Arithmetic shift floors toward minus infinity; the result always fits BITDEPTH.
    assign shifted      = product >>> ENVBITS;

    always_comb begin
        pcm_cap_d    = tick ? bus.pcm_in : pcm_cap_q;
        update_d     = tick;
        out_strobe_d = update_q;
        pcm_out_d    = pcm_out_q;
        if (update_q) begin
            pcm_out_d = BITDEPTH'(shifted) + MID_SCALE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            env_q          <= '0;
            sample_clock_q <= 1'b0;
            pcm_cap_q      <= MID_SCALE;
            update_q       <= 1'b0;
            pcm_out_q      <= MID_SCALE;
            out_strobe_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            env_q          <= env_d;
            sample_clock_q <= bus.sample_clock;
            pcm_cap_q      <= pcm_cap_d;
            update_q       <= update_d;
            pcm_out_q      <= pcm_out_d;
            out_strobe_q   <= out_strobe_d;
        end
    end

    assign bus.pcm_out    = pcm_out_q;
    assign bus.out_strobe = out_strobe_q;
    assign bus.env_level  = env_q;
    assign bus.active     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_adsr_envelope.sv
//------------------------------------------------------------------------------
// Module   : tb_adsr_envelope
// Summary  : Self-checking bench for adsr_envelope: vector table, random ticks, reset.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_adsr_envelope;

    localparam int BITDEPTH = 14;
    localparam int ENVBITS  = 12;
    localparam int ENV_MAX  = 4095;
    localparam int MID      = 8192;

    localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adsr_envelope_if #(.BITDEPTH(BITDEPTH), .ENVBITS(ENVBITS)) bus ();

    adsr_envelope #(.BITDEPTH(BITDEPTH), .ENVBITS(ENVBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int m_env   = 0;
    int m_phase = P_IDLE;
    int m_pcm   = MID;

    typedef struct {
        bit g;
        int a, d, s, r, pcm;
        int env;
        bit act;
        int out;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_pcm(input int pcm, input int env);
        int p, q;
        p = (pcm - MID) * env;
        q = p / 4096;
        if (p < 0 && (p % 4096) != 0) q = q - 1;
        return q + MID;
    endfunction

    task automatic model_attack(input int a);
        int t;
        t = m_env + a;
        if (a == 0 || t >= ENV_MAX) begin
            m_env = ENV_MAX; m_phase = P_DEC;
        end else begin
            m_env = t; m_phase = P_ATT;
        end
    endtask

    task automatic model_tick(input bit g, input int a, input int d, input int s, input int r);
        int t;
        if (m_phase == P_IDLE) begin
            if (g) model_attack(a);
            else m_env = 0;
        end else if (!g) begin
            t = m_env - r;
            if (r == 0 || t <= 0) begin
                m_env = 0; m_phase = P_IDLE;
            end else begin
                m_env = t; m_phase = P_REL;
            end
        end else if (m_phase == P_ATT || m_phase == P_REL) begin
            model_attack(a);
        end else if (m_phase == P_DEC) begin
            t = m_env - d;
            if (d == 0 || t <= s) begin
                m_env = s; m_phase = P_SUS;
            end else begin
                m_env = t;
            end
        end else begin
            m_env = s;
        end
    endtask

    // One sample period of four clocks; checks envelope, strobe timing and output.
    task automatic do_tick(input bit g, input int a, input int d, input int s,
                           input int r, input int pcm);
        logic [ENVBITS-1:0]  av, dv, sv, rv;
        logic [BITDEPTH-1:0] pv;
        av = a[ENVBITS-1:0]; dv = d[ENVBITS-1:0];
        sv = s[ENVBITS-1:0]; rv = r[ENVBITS-1:0];
        pv = pcm[BITDEPTH-1:0];
        @(negedge clk);
        bus.gate = g; bus.attack_step = av; bus.decay_step = dv;
        bus.sustain_level = sv; bus.release_step = rv; bus.pcm_in = pv;
        bus.sample_clock = 1'b1;
        model_tick(g, a, d, s, r);
        m_pcm = exp_pcm(pcm, m_env);
        @(negedge clk);
        check("env_level", 32'(bus.env_level), 32'(m_env));
        check("active", 32'(bus.active), 32'(m_phase != P_IDLE));
        check("strobe_early", 32'(bus.out_strobe), 32'd0);
        @(negedge clk);
        check("strobe_pulse", 32'(bus.out_strobe), 32'd1);
        check("pcm_out", 32'(bus.pcm_out), 32'(m_pcm));
        bus.sample_clock = 1'b0;
        @(negedge clk);
        check("strobe_late", 32'(bus.out_strobe), 32'd0);
        check("env_hold", 32'(bus.env_level), 32'(m_env));
    endtask

    task automatic add(input bit g, input int a, input int d, input int s, input int r,
                       input int pcm, input int env, input bit act, input int out);
        vec_t v;
        v.g = g; v.a = a; v.d = d; v.s = s; v.r = r; v.pcm = pcm;
        v.env = env; v.act = act; v.out = out;
        vecs.push_back(v);
    endtask

    initial begin
        bit g;
        int a, d, s, r;

        bus.sample_clock = 1'b0; bus.gate = 1'b0;
        bus.attack_step = '0; bus.decay_step = '0; bus.sustain_level = '0;
        bus.release_step = '0; bus.pcm_in = '0;

        #12;
        check("reset_env", 32'(bus.env_level), 32'd0);
        check("reset_active", 32'(bus.active), 32'd0);
        check("reset_pcm_out", 32'(bus.pcm_out), 32'd8192);
        check("reset_strobe", 32'(bus.out_strobe), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle ticks
        for (int i = 0; i < 3; i++) add(0, 1024, 512, 2048, 1000, 12000, 0, 0, 8192);
        // Attack / decay / sustain
        add(1, 1024, 512, 2048, 1000,  8192, 1024, 1,  8192);
        add(1, 1024, 512, 2048, 1000,  8192, 2048, 1,  8192);
        add(1, 1024, 512, 2048, 1000,  8192, 3072, 1,  8192);
        add(1, 1024, 512, 2048, 1000, 16383, 4095, 1, 16381);
        add(1, 1024, 512, 2048, 1000,  8192, 3583, 1,  8192);
        add(1, 1024, 512, 2048, 1000,  8192, 3071, 1,  8192);
        add(1, 1024, 512, 2048, 1000,  8192, 2559, 1,  8192);
        add(1, 1024, 512, 2048, 1000,  8192, 2048, 1,  8192);
        add(1, 1024, 512, 2048, 1000,  8192, 2048, 1,  8192);
        add(1, 1024, 512, 2048, 1000,     0, 2048, 1,  4096);
        // Release to idle
        add(0, 1024, 512, 2048, 1000,  8192, 1048, 1,  8192);
        add(0, 1024, 512, 2048, 1000,  8192,   48, 1,  8192);
        add(0, 1024, 512, 2048, 1000,  8192,    0, 0,  8192);
        // Retrigger during release
        add(1, 2048, 512, 2048, 1000,  8192, 2048, 1,  8192);
        add(0, 2048, 512, 2048, 1000,  8192, 1048, 1,  8192);
        add(1, 1024, 512, 2048, 1000,  8192, 2072, 1,  8192);
        add(0, 1024, 512, 2048,    0,  8192,    0, 0,  8192);
        // Instant steps, full-scale sustain, output extremes
        add(1, 0, 0, 4095, 0,     0, 4095, 1,     2);
        add(1, 0, 0, 4095, 0,  8192, 4095, 1,  8192);
        add(1, 0, 0, 4095, 0, 16383, 4095, 1, 16381);
        add(0, 0, 0, 4095, 0, 16383,    0, 0,  8192);
        add(1, 0, 0, 1500, 0,  8192, 4095, 1,  8192);
        add(1, 0, 0, 1500, 0,  8192, 1500, 1,  8192);
        add(0, 0, 0, 1500, 0,  8192,    0, 0,  8192);

        for (int i = 0; i < vecs.size(); i++) begin
            do_tick(vecs[i].g, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].r, vecs[i].pcm);
            check($sformatf("vec%0d_env", i), 32'(bus.env_level), 32'(vecs[i].env));
            check($sformatf("vec%0d_active", i), 32'(bus.active), 32'(vecs[i].act));
            check($sformatf("vec%0d_pcm_out", i), 32'(bus.pcm_out), 32'(vecs[i].out));
        end

        // Randomized ticks against the model
        g = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) g = ~g;
            a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1500));
            d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1500));
            r = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1500));
            s = int'($urandom_range(0, 4095));
            do_tick(g, a, d, s, r, int'($urandom_range(0, 16383)));
        end

        // Asynchronous reset in the middle of an attack
        do_tick(0, 0, 0, 0, 0, 8192);
        do_tick(1, 1024, 512, 2048, 1000, 16383);
        do_tick(1, 1024, 512, 2048, 1000, 16383);
        check("pre_rst_env", 32'(bus.env_level), 32'd2048);
        check("pre_rst_pcm_out", 32'(bus.pcm_out), 32'd12287);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_env", 32'(bus.env_level), 32'd0);
        check("async_rst_active", 32'(bus.active), 32'd0);
        check("async_rst_pcm_out", 32'(bus.pcm_out), 32'd8192);
        check("async_rst_strobe", 32'(bus.out_strobe), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_env = 0; m_phase = P_IDLE;
        do_tick(1, 1024, 512, 2048, 1000, 8192);
        check("post_rst_env", 32'(bus.env_level), 32'd1024);
        check("post_rst_active", 32'(bus.active), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
